checkfft_axil_slave: RTL and testbench
======================================

Name: checkfft_axil_slave

Overview:
AXI4-Lite slave (responder) that terminates the S00_AXI control port of the checkFFT peripheral. It is the counterpart to the master VIP used by the peripheral's BFM bench. It implements four 32-bit read/write control registers with byte strobes and exposes them, plus per-register write strobes, to the FFT datapath. It handles one outstanding write and one outstanding read at a time. Write and read channels operate independently.

Parameters:
C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
C_S_AXI_ADDR_WIDTH, 4, byte address width; addr[3:2] selects the register, addr[1:0] is ignored.
NUM_REGS, 4, number of registers; fixed at 2**(C_S_AXI_ADDR_WIDTH-2).

Ports:
s00_axi_aclk  in  1  single clock
s00_axi_areset  in  1  synchronous, active-high reset
s00_axi_awaddr  in  4  write address
s00_axi_awprot  in  3  ignored
s00_axi_awvalid  in  1  write address valid
s00_axi_awready  out  1  write address ready
s00_axi_wdata  in  32  write data
s00_axi_wstrb  in  4  byte-lane strobes
s00_axi_wvalid  in  1  write data valid
s00_axi_wready  out  1  write data ready
s00_axi_bresp  out  2  write response; always OKAY (2'b00)
s00_axi_bvalid  out  1  write response valid
s00_axi_bready  in  1  write response ready
s00_axi_araddr  in  4  read address
s00_axi_arprot  in  3  ignored
s00_axi_arvalid  in  1  read address valid
s00_axi_arready  out  1  read address ready
s00_axi_rdata  out  32  read data
s00_axi_rresp  out  2  read response; always OKAY
s00_axi_rvalid  out  1  read data valid
s00_axi_rready  in  1  read data ready
regs_o  out  128  registers concatenated; reg n at [32n+31:32n]
reg_wr_stb  out  4  one-cycle pulse per register written

Behaviour:
- Reset, sampled on the clock edge:
  - All registers are 0.
  - bvalid=0, rvalid=0, rdata=0, reg_wr_stb=0.
  - awready=1, wready=1, arready=1.
  - Both FSMs return to idle. Any in-flight transaction is dropped without a response.
- Write FSM states: W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP.
  - W_IDLE: awready=1, wready=1.
    - Both valid → write the register at that edge, go to W_RESP.
    - Only awvalid → latch the address, go to W_HAVE_AW.
    - Only wvalid → latch data and strobes, go to W_HAVE_W.
  - W_HAVE_AW: awready=0, wready=1. On wvalid, write the register and go to W_RESP.
  - W_HAVE_W: wready=0, awready=1. On awvalid, write the register and go to W_RESP.
  - W_RESP: awready=0, wready=0, bvalid=1. bvalid is held until bready is sampled high, then the FSM returns to W_IDLE. There is no combinational path from bready to awready or wready.
- Register update:
  - For each byte lane b with wstrb[b]=1, reg[addr[3:2]][8b+7:8b] takes wdata[8b+7:8b]. Lanes with wstrb[b]=0 keep their value.
  - reg_wr_stb[addr[3:2]]=1 for exactly the cycle after the update edge. This happens even when wstrb=0 (no bytes change, strobe still pulses).
- Write latency: with AW and W on the same edge k, the register changes at edge k and bvalid is high in cycle k+1. Fastest back-to-back write rate is one write per 2 cycles.
- Read FSM states: R_IDLE, R_DATA.
  - R_IDLE: arready=1. On arvalid, rdata takes reg[araddr[3:2]] (value before any same-edge write), go to R_DATA.
  - R_DATA: arready=0, rvalid=1, rdata held stable until rready, then return to R_IDLE.
- Read latency: rvalid is high in the cycle after the AR handshake.
- Simultaneous write and read of the same register on the same edge: the read returns the old value. A read accepted on any later edge returns the new value.
- Both channels may be active concurrently; neither FSM stalls the other.
- bresp and rresp are constant 2'b00. There is no decode error because all addresses map to a register.

Decomposition:
- Package checkfft_axil_pkg holds:
  - Constants: AXI_RESP_OKAY, C_REG_IDX_LSB=2, NUM_REGS.
  - Typedefs: wr_state_t {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} and rd_state_t {R_IDLE, R_DATA}.
- A single flat module is natural. The byte-strobe merge is a function in the package (apply_wstrb(old, data, strb)); there is no sub-module.

Test Plan:
- Four sequential writes of 0x1, 0x2, 0x3, 0x4 to addresses 0x0, 0x4, 0x8, 0xC (wstrb=0xF), then four reads → read data 0x1, 0x2, 0x3, 0x4; all bresp and rresp are OKAY; regs_o=0x00000004_00000003_00000002_00000001.
- AW presented 3 cycles before W at address 0x8 → awready drops after the AW handshake, the register changes only on the W edge, reg_wr_stb=4'b0100 for one cycle, one bvalid.
- Write 0xFFFFFFFF to 0x4, then write 0x12345678 with wstrb=4'b0101 → reading 0x4 returns 0xFF34FF78.
- Same-edge write of 0xA5A5A5A5 to 0x0 and read of 0x0 that previously held 0x1 → rdata=0x1; the next read returns 0xA5A5A5A5.
- bready held low 10 cycles and rready held low 10 cycles → bvalid, rvalid and rdata stay stable, no new AW/W/AR is accepted, and the response completes when ready rises.
- Reset asserted while in W_HAVE_AW and R_DATA → next cycle all registers are 0, bvalid=0, rvalid=0, and awready, wready, arready are all 1.

Source files
------------

// File: rtl/checkfft_axil_pkg.sv
// Shared constants, FSM state types and the byte-strobe merge for the
// checkFFT AXI4-Lite control slave.
package checkfft_axil_pkg;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
  localparam int         C_REG_IDX_LSB = 2;
  localparam int         NUM_REGS      = 4;

  typedef enum logic [1:0] {
    W_IDLE,
    W_HAVE_AW,
    W_HAVE_W,
    W_RESP
  } wr_state_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_t;

  // Lanes with a clear strobe keep their old byte.
  function automatic logic [31:0] apply_wstrb(input logic [31:0] old,
                                              input logic [31:0] data,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = data[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/checkfft_axil_slave.sv
// AXI4-Lite slave for the checkFFT S00_AXI control port: four 32-bit
// byte-strobed registers with per-register write pulses.
//
// state      | meaning
// W_IDLE     | ready for AW and W, either order or together
// W_HAVE_AW  | address latched, waiting for write data
// W_HAVE_W   | data and strobes latched, waiting for address
// W_RESP     | register written, bvalid held until bready
// R_IDLE     | ready for AR
// R_DATA     | rdata captured, rvalid held until rready
module checkfft_axil_slave
  import checkfft_axil_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                                   s00_axi_aclk,
  input  logic                                   s00_axi_areset,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          s00_axi_awaddr,
  input  logic [2:0]                             s00_axi_awprot,
  input  logic                                   s00_axi_awvalid,
  output logic                                   s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]          s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        s00_axi_wstrb,
  input  logic                                   s00_axi_wvalid,
  output logic                                   s00_axi_wready,
  output logic [1:0]                             s00_axi_bresp,
  output logic                                   s00_axi_bvalid,
  input  logic                                   s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          s00_axi_araddr,
  input  logic [2:0]                             s00_axi_arprot,
  input  logic                                   s00_axi_arvalid,
  output logic                                   s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]          s00_axi_rdata,
  output logic [1:0]                             s00_axi_rresp,
  output logic                                   s00_axi_rvalid,
  input  logic                                   s00_axi_rready,
  output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] regs_o,
  output logic [NUM_REGS-1:0]                    reg_wr_stb
);

  localparam int IDX_W = C_S_AXI_ADDR_WIDTH - C_REG_IDX_LSB;

  wr_state_t wr_state_q, wr_state_d;
  rd_state_t rd_state_q, rd_state_d;

  logic [31:0]      regs_q [NUM_REGS];
  logic [IDX_W-1:0] aw_idx, ar_idx, aw_idx_q;
  logic [31:0]      w_data_q;
  logic [3:0]       w_strb_q;

  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [31:0]      wr_data;
  logic [3:0]       wr_strb;
  logic             rd_fire;

  logic unused_ok;
  assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot,
                       s00_axi_awaddr[C_REG_IDX_LSB-1:0],
                       s00_axi_araddr[C_REG_IDX_LSB-1:0]};

  assign aw_idx        = s00_axi_awaddr[C_REG_IDX_LSB +: IDX_W];
  assign ar_idx        = s00_axi_araddr[C_REG_IDX_LSB +: IDX_W];
  assign s00_axi_bresp = AXI_RESP_OKAY;
  assign s00_axi_rresp = AXI_RESP_OKAY;

  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      wr_state_q <= W_IDLE;
      rd_state_q <= R_IDLE;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
    end
  end

  // Ready/valid come only from state, so bready never reaches awready/wready.
  always_comb begin
    wr_state_d      = wr_state_q;
    s00_axi_awready = 1'b0;
    s00_axi_wready  = 1'b0;
    s00_axi_bvalid  = 1'b0;
    wr_en           = 1'b0;
    wr_idx          = aw_idx_q;
    wr_data         = w_data_q;
    wr_strb         = w_strb_q;
    unique case (wr_state_q)
      W_IDLE: begin
        s00_axi_awready = 1'b1;
        s00_axi_wready  = 1'b1;
        if (s00_axi_awvalid && s00_axi_wvalid) begin
          wr_en      = 1'b1;
          wr_idx     = aw_idx;
          wr_data    = s00_axi_wdata;
          wr_strb    = s00_axi_wstrb;
          wr_state_d = W_RESP;
        end else if (s00_axi_awvalid) begin
          wr_state_d = W_HAVE_AW;
        end else if (s00_axi_wvalid) begin
          wr_state_d = W_HAVE_W;
        end
      end
      W_HAVE_AW: begin
        s00_axi_wready = 1'b1;
        if (s00_axi_wvalid) begin
          wr_en      = 1'b1;
          wr_data    = s00_axi_wdata;
          wr_strb    = s00_axi_wstrb;
          wr_state_d = W_RESP;
        end
      end
      W_HAVE_W: begin
        s00_axi_awready = 1'b1;
        if (s00_axi_awvalid) begin
          wr_en      = 1'b1;
          wr_idx     = aw_idx;
          wr_state_d = W_RESP;
        end
      end
      W_RESP: begin
        s00_axi_bvalid = 1'b1;
        if (s00_axi_bready) wr_state_d = W_IDLE;
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    rd_state_d      = rd_state_q;
    s00_axi_arready = (rd_state_q == R_IDLE);
    s00_axi_rvalid  = (rd_state_q == R_DATA);
    rd_fire         = 1'b0;
    unique case (rd_state_q)
      R_IDLE: begin
        if (s00_axi_arvalid) begin
          rd_fire    = 1'b1;
          rd_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (s00_axi_rready) rd_state_d = R_IDLE;
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  // A same-edge read samples regs_q before the write lands, returning the old value.
  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      for (int n = 0; n < NUM_REGS; n++) regs_q[n] <= '0;
      reg_wr_stb    <= '0;
      s00_axi_rdata <= '0;
      aw_idx_q      <= '0;
      w_data_q      <= '0;
      w_strb_q      <= '0;
    end else begin
      reg_wr_stb <= '0;
      if (s00_axi_awvalid && s00_axi_awready) aw_idx_q <= aw_idx;
      if (s00_axi_wvalid && s00_axi_wready) begin
        w_data_q <= s00_axi_wdata;
        w_strb_q <= s00_axi_wstrb;
      end
      if (wr_en) begin
        regs_q[wr_idx]     <= apply_wstrb(regs_q[wr_idx], wr_data, wr_strb);
        reg_wr_stb[wr_idx] <= 1'b1;
      end
      if (rd_fire) s00_axi_rdata <= regs_q[ar_idx];
    end
  end

  always_comb begin
    regs_o = '0;
    for (int n = 0; n < NUM_REGS; n++) regs_o[32*n +: 32] = regs_q[n];
  end

endmodule

// File: tb/tb_checkfft_axil_slave.sv
// Directed plus randomized bench for checkfft_axil_slave against an
// array-based register model.
module tb_checkfft_axil_slave;

  logic         clk = 1'b0;
  logic         areset;
  logic [3:0]   awaddr, araddr;
  logic [2:0]   awprot, arprot;
  logic         awvalid, awready, wvalid, wready, bvalid, bready;
  logic         arvalid, arready, rvalid, rready;
  logic [31:0]  wdata, rdata;
  logic [3:0]   wstrb, wr_stb;
  logic [1:0]   bresp, rresp;
  logic [127:0] regs_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] mdl [4];

  always #5 clk = ~clk;

  checkfft_axil_slave dut (
    .s00_axi_aclk   (clk),
    .s00_axi_areset (areset),
    .s00_axi_awaddr (awaddr),
    .s00_axi_awprot (awprot),
    .s00_axi_awvalid(awvalid),
    .s00_axi_awready(awready),
    .s00_axi_wdata  (wdata),
    .s00_axi_wstrb  (wstrb),
    .s00_axi_wvalid (wvalid),
    .s00_axi_wready (wready),
    .s00_axi_bresp  (bresp),
    .s00_axi_bvalid (bvalid),
    .s00_axi_bready (bready),
    .s00_axi_araddr (araddr),
    .s00_axi_arprot (arprot),
    .s00_axi_arvalid(arvalid),
    .s00_axi_arready(arready),
    .s00_axi_rdata  (rdata),
    .s00_axi_rresp  (rresp),
    .s00_axi_rvalid (rvalid),
    .s00_axi_rready (rready),
    .regs_o         (regs_o),
    .reg_wr_stb     (wr_stb)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                        input logic [3:0] strb);
    logic [31:0] mask;
    mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    return (old & ~mask) | (data & mask);
  endfunction

  function automatic logic [127:0] regs_exp();
    return {mdl[3], mdl[2], mdl[1], mdl[0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int n;
    logic [3:0] onehot;
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    while (!(awready && wready) && n < 20) begin tick(); n++; end
    chk("wr_ready_wait", 128'(n < 20), 128'(1));
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    mdl[addr[3:2]] = merge(mdl[addr[3:2]], data, strb);
    onehot = 4'b0001 << addr[3:2];
    chk("wr_bvalid", 128'(bvalid), 128'(1));
    chk("wr_bresp", 128'(bresp), 128'(0));
    chk("wr_stb", 128'(wr_stb), 128'(onehot));
    chk("wr_regs", regs_o, regs_exp());
    bready = 1'b1;
    tick();
    bready = 1'b0;
    chk("wr_bvalid_clr", 128'(bvalid), 128'(0));
    chk("wr_stb_clr", 128'(wr_stb), 128'(0));
  endtask

  task automatic axi_read(input logic [3:0] addr);
    int n;
    logic [31:0] exp;
    araddr = addr; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 20) begin tick(); n++; end
    chk("rd_ready_wait", 128'(n < 20), 128'(1));
    exp = mdl[addr[3:2]];
    tick();
    arvalid = 1'b0;
    chk("rd_rvalid", 128'(rvalid), 128'(1));
    chk("rd_rdata", 128'(rdata), 128'(exp));
    chk("rd_rresp", 128'(rresp), 128'(0));
    rready = 1'b1;
    tick();
    rready = 1'b0;
    chk("rd_rvalid_clr", 128'(rvalid), 128'(0));
  endtask

  initial begin
    logic [31:0] old0, hold_rdata;
    logic [127:0] hold_regs;
    logic [3:0] ra, wa;

    areset = 1'b1;
    awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    bready = 1'b0; rready = 1'b0;
    wdata = '0; wstrb = '0;
    for (int i = 0; i < 4; i++) mdl[i] = '0;
    tick(); tick();
    areset = 1'b0;
    chk("rst_regs", regs_o, 128'(0));
    chk("rst_bvalid", 128'(bvalid), 128'(0));
    chk("rst_rvalid", 128'(rvalid), 128'(0));
    chk("rst_rdata", 128'(rdata), 128'(0));
    chk("rst_stb", 128'(wr_stb), 128'(0));
    chk("rst_readys", 128'({awready, wready, arready}), 128'(3'b111));

    // Sequential writes then reads of all four registers.
    for (int i = 0; i < 4; i++) axi_write(4'(4 * i), 32'(i + 1), 4'hF);
    for (int i = 0; i < 4; i++) axi_read(4'(4 * i));
    chk("seq_regs_o", regs_o, 128'h00000004_00000003_00000002_00000001);

    // AW three cycles ahead of W at 0x8.
    awaddr = 4'h8; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    chk("aw_first_awready", 128'(awready), 128'(0));
    chk("aw_first_wready", 128'(wready), 128'(1));
    for (int i = 0; i < 2; i++) begin
      chk("aw_first_hold_regs", regs_o, regs_exp());
      chk("aw_first_hold_stb", 128'(wr_stb), 128'(0));
      chk("aw_first_hold_bvalid", 128'(bvalid), 128'(0));
      tick();
    end
    chk("aw_first_pre_regs", regs_o, regs_exp());
    wdata = 32'hCAFE_0008; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    mdl[2] = 32'hCAFE_0008;
    chk("aw_first_regs", regs_o, regs_exp());
    chk("aw_first_stb", 128'(wr_stb), 128'(4'b0100));
    chk("aw_first_bvalid", 128'(bvalid), 128'(1));
    bready = 1'b1;
    tick();
    bready = 1'b0;
    chk("aw_first_stb_clr", 128'(wr_stb), 128'(0));
    chk("aw_first_bvalid_clr", 128'(bvalid), 128'(0));

    // W ahead of AW at 0xC with a partial strobe.
    wdata = 32'h1122_3344; wstrb = 4'b0011; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    chk("w_first_wready", 128'(wready), 128'(0));
    chk("w_first_awready", 128'(awready), 128'(1));
    tick();
    chk("w_first_hold_regs", regs_o, regs_exp());
    awaddr = 4'hC; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    mdl[3] = merge(mdl[3], 32'h1122_3344, 4'b0011);
    chk("w_first_regs", regs_o, regs_exp());
    chk("w_first_stb", 128'(wr_stb), 128'(4'b1000));
    bready = 1'b1;
    tick();
    bready = 1'b0;

    // Byte-strobe merge.
    axi_write(4'h4, 32'hFFFF_FFFF, 4'hF);
    axi_write(4'h4, 32'h1234_5678, 4'b0101);
    chk("strb_merge", 128'(mdl[1]), 128'(32'hFF34_FF78));
    axi_read(4'h4);

    // Same-edge write and read of register 0.
    old0 = mdl[0];
    awaddr = 4'h0; wdata = 32'hA5A5_A5A5; wstrb = 4'hF;
    araddr = 4'h0;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    mdl[0] = 32'hA5A5_A5A5;
    chk("same_edge_old", 128'(rdata), 128'(old0));
    chk("same_edge_old_is_1", 128'(rdata), 128'(32'h1));
    chk("same_edge_regs", regs_o, regs_exp());
    bready = 1'b1; rready = 1'b1;
    tick();
    bready = 1'b0; rready = 1'b0;
    axi_read(4'h0);

    // Back-pressure on B and R with new requests held pending.
    awaddr = 4'hC; wdata = 32'h5555_AAAA; wstrb = 4'hF; araddr = 4'h4;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    hold_rdata = mdl[1];
    tick();
    mdl[3] = 32'h5555_AAAA;
    awaddr = 4'h0; wdata = 32'hDEAD_BEEF; araddr = 4'h8;
    hold_regs = regs_exp();
    for (int i = 0; i < 10; i++) begin
      chk("stall_bvalid", 128'(bvalid), 128'(1));
      chk("stall_rvalid", 128'(rvalid), 128'(1));
      chk("stall_rdata", 128'(rdata), 128'(hold_rdata));
      chk("stall_readys", 128'({awready, wready, arready}), 128'(3'b000));
      chk("stall_regs", regs_o, hold_regs);
      tick();
    end
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    bready = 1'b1; rready = 1'b1;
    tick();
    bready = 1'b0; rready = 1'b0;
    chk("stall_done_valids", 128'({bvalid, rvalid}), 128'(2'b00));
    chk("stall_done_regs", regs_o, regs_exp());

    // Randomized writes and reads, including zero strobes.
    for (int i = 0; i < 40; i++) begin
      wa = 4'($urandom_range(0, 15));
      ra = 4'($urandom_range(0, 15));
      axi_write(wa, $urandom, 4'($urandom_range(0, 15)));
      axi_read(ra);
    end
    axi_write(4'h9, 32'hFFFF_FFFF, 4'h0);
    chk("rand_regs_o", regs_o, regs_exp());

    // Reset while W_HAVE_AW and R_DATA are pending.
    awaddr = 4'h4; awvalid = 1'b1; araddr = 4'h4; arvalid = 1'b1;
    tick();
    awvalid = 1'b0; arvalid = 1'b0;
    chk("pre_rst_awready", 128'(awready), 128'(0));
    chk("pre_rst_rvalid", 128'(rvalid), 128'(1));
    areset = 1'b1;
    tick();
    areset = 1'b0;
    for (int i = 0; i < 4; i++) mdl[i] = '0;
    chk("mid_rst_regs", regs_o, regs_exp());
    chk("mid_rst_valids", 128'({bvalid, rvalid}), 128'(2'b00));
    chk("mid_rst_readys", 128'({awready, wready, arready}), 128'(3'b111));
    axi_write(4'h8, 32'h0BAD_F00D, 4'hF);
    axi_read(4'h8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
